ysyx_22040750_csr_unit: RTL
===========================

YSYX_22040750_CSR_UNIT -- requirements
Module: ysyx_22040750_csr_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, CSR data width (32 or 64).
REQ-002 SHALL have parameter PC_W, default 32, trap PC width (PC_W <= XLEN).
REQ-003 SHALL have parameter VEC_EN, default 1; when 1, mtvec vectored mode is honoured.
REQ-004 SHALL have parameter CNT_EN, default 1; when 1, mcycle/minstret are implemented, else they read 0.
REQ-005 I_sys_clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 I_rst  in  1  reset, synchronous, active-high.
REQ-007 I_msip / I_mtip / I_meip  in  1 each  software / timer / external interrupt levels.
REQ-008 I_valid  in  1  commit qualifier; gates every write strobe below.
REQ-009 I_retire  in  1  one instruction retires this cycle (counted only with I_valid).
REQ-010 I_csr_wen  in  1  CSR write strobe.
REQ-011 I_wr_addr / I_rd_addr  in  12 each  CSR write / read address.
REQ-012 I_wr_data  in  XLEN  CSR write data.
REQ-013 I_trap_wr  in  1  take trap; I_trap_cause  in  XLEN  mcause value; I_trap_pc  in  PC_W  faulting PC.
REQ-014 I_mret_wr  in  1  execute mret.
REQ-015 O_rd_data  out  XLEN  combinational read data.
REQ-016 O_rd_illegal  out  1  I_rd_addr not implemented.
REQ-017 O_intr  out  1  interrupt request; O_intr_cause  out  XLEN  cause for that request.
REQ-018 O_trap_vec  out  XLEN  trap target PC; O_mepc  out  XLEN  mret target.

Function
REQ-019 Implemented CSRs: satp 0x180, mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, minstret 0xB02.
REQ-020 Effective strobes SHALL be raw strobe AND I_valid; priority trap > mret > CSR write; only the winner acts in a cycle.
REQ-021 mip bits 3/7/11 SHALL register I_msip/I_mtip/I_meip every cycle (1-cycle latency), independent of writes; CSR writes to mip are ignored.
REQ-022 O_intr = mstatus.MIE AND |(mip & mie restricted to bits 3/7/11), combinational from registers.
REQ-023 O_intr_cause = MSB 1, code 11 if MEI pending-enabled, else 3 (MSI), else 7 (MTI); 0 when O_intr is 0.
REQ-024 Trap: mepc <= zero-extended I_trap_pc with bits[1:0] cleared; mcause <= I_trap_cause; MPIE <= MIE; MIE <= 0; MPP <= 2'b11.
REQ-025 mret: MIE <= MPIE; MPIE <= 1; MPP <= 2'b11.
REQ-026 mtvec writes: bit 1 forced 0; bit 0 forced 0 when VEC_EN=0.
REQ-027 mstatus writes: MPP forced 2'b11; other bits as written.
REQ-028 O_trap_vec = {mtvec[XLEN-1:2],2'b00} + 4*code when mtvec[0]=1 and I_trap_cause MSB=1, else base only.
REQ-029 O_mepc = mepc combinationally; write-then-read reflects the new value the next cycle.
REQ-030 mcycle increments by 1 every cycle, wrapping at 2^XLEN to 0; a CSR write to mcycle loads I_wr_data and suppresses that cycle's increment.
REQ-031 minstret increments on I_valid & I_retire, wraps likewise; CSR write same cycle wins, no increment.
REQ-032 Reads of unimplemented addresses SHALL return 0 with O_rd_illegal=1; writes to them are dropped.

Reset
REQ-033 On I_rst: mstatus = 0xA00001800 (XLEN=64) or 0x1800 (XLEN=32); all other CSRs, counters and mip = 0.
REQ-034 Reset SHALL dominate any concurrent strobe; O_intr=0 the cycle after reset.

Structure
REQ-035 Package ysyx_22040750_csr_pkg SHALL hold CSR addresses, mstatus bit indices, interrupt codes 3/7/11 and reset constants.
REQ-036 Sub-module ysyx_22040750_csr_counter (XLEN-wide, increment enable, load, wrap) SHALL be instantiated for mcycle and minstret.

Verification
REQ-037 Reset, read 0x300 -> 0xA00001800; read 0x7C0 -> 0, O_rd_illegal=1.
REQ-038 mie=0x888, MIE=1, assert I_meip and I_mtip together -> one cycle later O_intr=1, O_intr_cause=0x800000000000000B.
REQ-039 mtvec=0x80000001, I_trap_cause=0x8000000000000007 -> O_trap_vec=0x8000001C; trap_wr with pc 0x80000104 -> mepc 0x80000104, MIE=0, MPIE=1.
REQ-040 Trap and CSR write to mepc same cycle -> trap wins; then mret -> MIE=1, MPIE=1.
REQ-041 Write mcycle=0xFFFFFFFFFFFFFFFF -> following cycle reads 0 (wrap); write minstret with I_retire=1 -> written value, no increment.
REQ-042 Strobes with I_valid=0 -> no CSR change.

Source files
------------

// File: rtl/ysyx_22040750_csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, mstatus fields,
// interrupt codes and reset values.
package ysyx_22040750_csr_pkg;

  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  localparam logic [63:0] MSTATUS_RST_64 = 64'h0000_000A_0000_1800;
  localparam logic [31:0] MSTATUS_RST_32 = 32'h0000_1800;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_WRITE,
    ACT_MRET,
    ACT_TRAP
  } csr_act_e;

  // Fixed priority among pending-and-enabled sources: external, software, timer.
  function automatic logic [3:0] irq_code(input logic mei, input logic msi, input logic mti);
    logic [3:0] code;
    code = 4'd0;
    if (mei)      code = 4'(IRQ_MEI);
    else if (msi) code = 4'(IRQ_MSI);
    else if (mti) code = 4'(IRQ_MTI);
    return code;
  endfunction

endpackage

// File: rtl/ysyx_22040750_csr_if.sv
// Commit-side bus of the CSR unit: strobes, interrupt levels, read port and
// trap/return targets.
interface ysyx_22040750_csr_if #(
  parameter int XLEN = 64,
  parameter int PC_W = 32
);
  logic            I_msip;
  logic            I_mtip;
  logic            I_meip;
  logic            I_valid;
  logic            I_retire;
  logic            I_csr_wen;
  logic [11:0]     I_wr_addr;
  logic [11:0]     I_rd_addr;
  logic [XLEN-1:0] I_wr_data;
  logic            I_trap_wr;
  logic [XLEN-1:0] I_trap_cause;
  logic [PC_W-1:0] I_trap_pc;
  logic            I_mret_wr;
  logic [XLEN-1:0] O_rd_data;
  logic            O_rd_illegal;
  logic            O_intr;
  logic [XLEN-1:0] O_intr_cause;
  logic [XLEN-1:0] O_trap_vec;
  logic [XLEN-1:0] O_mepc;

  modport slave (
    input  I_msip, I_mtip, I_meip, I_valid, I_retire, I_csr_wen,
           I_wr_addr, I_rd_addr, I_wr_data, I_trap_wr, I_trap_cause,
           I_trap_pc, I_mret_wr,
    output O_rd_data, O_rd_illegal, O_intr, O_intr_cause, O_trap_vec, O_mepc
  );

  modport master (
    output I_msip, I_mtip, I_meip, I_valid, I_retire, I_csr_wen,
           I_wr_addr, I_rd_addr, I_wr_data, I_trap_wr, I_trap_cause,
           I_trap_pc, I_mret_wr,
    input  O_rd_data, O_rd_illegal, O_intr, O_intr_cause, O_trap_vec, O_mepc
  );
endinterface

// File: rtl/ysyx_22040750_csr_counter.sv
// Free-running wrap-around counter with a load port; a load wins over the
// increment in the same cycle.
module ysyx_22040750_csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            I_sys_clk,
  input  logic            I_rst,
  input  logic            I_inc,
  input  logic            I_load,
  input  logic [XLEN-1:0] I_load_val,
  output logic [XLEN-1:0] O_cnt
);

  logic [XLEN-1:0] cnt_q;
  logic [XLEN-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (I_load)     cnt_d = I_load_val;
    else if (I_inc) cnt_d = cnt_q + XLEN'(1);
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign O_cnt = cnt_q;

endmodule

// File: rtl/ysyx_22040750_csr_unit.sv
// Machine-mode CSR file: trap entry/return, interrupt arbitration, vectored
// trap target and the cycle/instret counters.
module ysyx_22040750_csr_unit
  import ysyx_22040750_csr_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int PC_W   = 32,
  parameter int VEC_EN = 1,
  parameter int CNT_EN = 1
) (
  input  logic                      I_sys_clk,
  input  logic                      I_rst,
  ysyx_22040750_csr_if.slave        csr_bus
);

  localparam logic [XLEN-1:0] MSTATUS_RST =
    (XLEN == 64) ? XLEN'(MSTATUS_RST_64) : XLEN'(MSTATUS_RST_32);

  logic [XLEN-1:0] satp_q, satp_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mcycle, minstret;

  csr_act_e act;
  logic     mcycle_ld, minstret_ld, retire_en;

  // Only one of trap / mret / write takes effect in a cycle.
  always_comb begin
    act = ACT_NONE;
    if (csr_bus.I_valid) begin
      if (csr_bus.I_trap_wr)      act = ACT_TRAP;
      else if (csr_bus.I_mret_wr) act = ACT_MRET;
      else if (csr_bus.I_csr_wen) act = ACT_WRITE;
    end
  end

  assign mcycle_ld   = (act == ACT_WRITE) && (csr_bus.I_wr_addr == CSR_MCYCLE);
  assign minstret_ld = (act == ACT_WRITE) && (csr_bus.I_wr_addr == CSR_MINSTRET);
  assign retire_en   = csr_bus.I_valid & csr_bus.I_retire;

  always_comb begin
    satp_d     = satp_q;
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mip_d          = '0;
    mip_d[IRQ_MSI] = csr_bus.I_msip;
    mip_d[IRQ_MTI] = csr_bus.I_mtip;
    mip_d[IRQ_MEI] = csr_bus.I_meip;
    unique case (act)
      ACT_TRAP: begin
        mepc_d       = XLEN'(csr_bus.I_trap_pc);
        mepc_d[1:0]  = 2'b00;
        mcause_d     = csr_bus.I_trap_cause;
        mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
        mstatus_d[MSTATUS_MIE]  = 1'b0;
        mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      ACT_MRET: begin
        mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
        mstatus_d[MSTATUS_MPIE] = 1'b1;
        mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      ACT_WRITE: begin
        unique case (csr_bus.I_wr_addr)
          CSR_SATP:     satp_d = csr_bus.I_wr_data;
          CSR_MSTATUS: begin
            mstatus_d = csr_bus.I_wr_data;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
          end
          CSR_MIE:      mie_d = csr_bus.I_wr_data;
          CSR_MTVEC: begin
            mtvec_d    = csr_bus.I_wr_data;
            mtvec_d[1] = 1'b0;
            if (VEC_EN == 0) mtvec_d[0] = 1'b0;
          end
          CSR_MSCRATCH: mscratch_d = csr_bus.I_wr_data;
          CSR_MEPC:     mepc_d     = csr_bus.I_wr_data;
          CSR_MCAUSE:   mcause_d   = csr_bus.I_wr_data;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      satp_q     <= '0;
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mip_q      <= '0;
    end else begin
      satp_q     <= satp_d;
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mip_q      <= mip_d;
    end
  end

  if (CNT_EN != 0) begin : g_cnt
    ysyx_22040750_csr_counter #(.XLEN(XLEN)) u_mcycle (
      .I_sys_clk  (I_sys_clk),
      .I_rst      (I_rst),
      .I_inc      (1'b1),
      .I_load     (mcycle_ld),
      .I_load_val (csr_bus.I_wr_data),
      .O_cnt      (mcycle)
    );
    ysyx_22040750_csr_counter #(.XLEN(XLEN)) u_minstret (
      .I_sys_clk  (I_sys_clk),
      .I_rst      (I_rst),
      .I_inc      (retire_en),
      .I_load     (minstret_ld),
      .I_load_val (csr_bus.I_wr_data),
      .O_cnt      (minstret)
    );
  end else begin : g_no_cnt
    assign mcycle   = '0;
    assign minstret = '0;
  end

  always_comb begin
    csr_bus.O_rd_data    = '0;
    csr_bus.O_rd_illegal = 1'b0;
    unique case (csr_bus.I_rd_addr)
      CSR_SATP:     csr_bus.O_rd_data = satp_q;
      CSR_MSTATUS:  csr_bus.O_rd_data = mstatus_q;
      CSR_MIE:      csr_bus.O_rd_data = mie_q;
      CSR_MTVEC:    csr_bus.O_rd_data = mtvec_q;
      CSR_MSCRATCH: csr_bus.O_rd_data = mscratch_q;
      CSR_MEPC:     csr_bus.O_rd_data = mepc_q;
      CSR_MCAUSE:   csr_bus.O_rd_data = mcause_q;
      CSR_MIP:      csr_bus.O_rd_data = mip_q;
      CSR_MCYCLE:   csr_bus.O_rd_data = mcycle;
      CSR_MINSTRET: csr_bus.O_rd_data = minstret;
      default:      csr_bus.O_rd_illegal = 1'b1;
    endcase
  end

  logic [XLEN-1:0] pend;
  logic [3:0]      intr_code;
  logic [XLEN-1:0] trap_base;

  assign pend      = mip_q & mie_q;
  assign intr_code = irq_code(pend[IRQ_MEI], pend[IRQ_MSI], pend[IRQ_MTI]);

  always_comb begin
    csr_bus.O_intr       = mstatus_q[MSTATUS_MIE] &
                           (pend[IRQ_MEI] | pend[IRQ_MSI] | pend[IRQ_MTI]);
    csr_bus.O_intr_cause = '0;
    if (csr_bus.O_intr) begin
      csr_bus.O_intr_cause[XLEN-1] = 1'b1;
      csr_bus.O_intr_cause[3:0]    = intr_code;
    end
  end

  // Vectored mode applies only to interrupts; exceptions go to the base.
  always_comb begin
    trap_base          = {mtvec_q[XLEN-1:2], 2'b00};
    csr_bus.O_trap_vec = trap_base;
    if (mtvec_q[0] && csr_bus.I_trap_cause[XLEN-1])
      csr_bus.O_trap_vec = trap_base + {csr_bus.I_trap_cause[XLEN-3:0], 2'b00};
  end

  assign csr_bus.O_mepc = mepc_q;

endmodule
